// File: rtl/conv_mem_arb.sv
// conv_mem_arb: round-robin arbiter sharing the single CONV result-memory port
// between NREQ internal engines. One memory access per cycle, all memory-side
// outputs registered, read data steered back to the issuing engine in order.
module conv_mem_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20,
    parameter int SW   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*SW-1:0] req_sel,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               crd,
    output logic               cwr,
    output logic [SW-1:0]      csel,
    output logic [AW-1:0]      caddr_rd,
    output logic [AW-1:0]      caddr_wr,
    output logic [DW-1:0]      cdata_wr,
    input  logic [DW-1:0]      cdata_rd,
    output logic               arb_busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] act;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  cand;
    logic            gnt_any;
    logic            rd_accept;
    logic [SW-1:0]   sel_g;
    logic [AW-1:0]   addr_g;
    logic [DW-1:0]   wdata_g;

    // Read tag pipe: stage 0 covers the crd cycle, stage 1 the rvalid cycle.
    logic            t0_v;
    logic [IDW-1:0]  t0_id;
    logic            t1_v;

    // Engine index offset positions above base, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[IDW-1:0];
    endfunction

    assign act       = req_rd | req_wr;
    assign ptr_next  = rr_index(gnt_id, 1);
    assign sel_g     = req_sel[int'(gnt_id)*SW +: SW];
    assign addr_g    = req_addr[int'(gnt_id)*AW +: AW];
    assign wdata_g   = req_wdata[int'(gnt_id)*DW +: DW];
    // A write wins when an engine asks for both; its read waits for a later turn.
    assign rd_accept = gnt_any & ~req_wr[gnt_id];
    assign arb_busy  = (|act) | t0_v | t1_v;

    // Grant the first active engine found searching upward from ptr with wrap.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_index(ptr, k);
            if (!gnt_any && act[cand]) begin
                gnt[cand] = 1'b1;
                gnt_id    = cand;
                gnt_any   = 1'b1;
            end
        end
    end

    // Launch the granted access onto the memory port and advance the pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
        end else if (gnt_any) begin
            ptr  <= ptr_next;
            csel <= sel_g;
            if (req_wr[gnt_id]) begin
                cwr      <= 1'b1;
                crd      <= 1'b0;
                caddr_wr <= addr_g;
                cdata_wr <= wdata_g;
            end else begin
                crd      <= 1'b1;
                cwr      <= 1'b0;
                caddr_rd <= addr_g;
            end
        end else begin
            crd  <= 1'b0;
            cwr  <= 1'b0;
            csel <= '0;
        end
    end

    // Track reads in flight and return the memory data to the issuing engine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t0_v   <= 1'b0;
            t0_id  <= '0;
            t1_v   <= 1'b0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            t0_v   <= rd_accept;
            t0_id  <= gnt_id;
            t1_v   <= t0_v;
            rvalid <= '0;
            if (t0_v) begin
                rvalid[t0_id] <= 1'b1;
                rdata         <= cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_conv_mem_arb.sv
// tb_conv_mem_arb: directed and randomized checks of conv_mem_arb against a
// transaction-level model (round-robin pick, shadow memory, return queue).
module tb_conv_mem_arb;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;
    localparam int SW   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*SW-1:0] req_sel;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               crd;
    logic               cwr;
    logic [SW-1:0]      csel;
    logic [AW-1:0]      caddr_rd;
    logic [AW-1:0]      caddr_wr;
    logic [DW-1:0]      cdata_wr;
    logic [DW-1:0]      cdata_rd = '0;
    logic               arb_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    conv_mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .crd       (crd),
        .cwr       (cwr),
        .csel      (csel),
        .caddr_rd  (caddr_rd),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .cdata_rd  (cdata_rd),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    function automatic bit bank_ok(input logic [SW-1:0] s);
        return (s >= 3'd1) && (s <= 3'd5);
    endfunction

    function automatic int mkey(input logic [SW-1:0] s, input logic [AW-1:0] a);
        return int'({s, a});
    endfunction

    // External memory: writes at the rising edge ending a cwr cycle, read data
    // appears at the falling edge inside a crd cycle.
    logic [DW-1:0] mem [int];

    always @(posedge clk) begin
        if (cwr && bank_ok(csel)) begin
            mem[mkey(csel, caddr_wr)] = cdata_wr;
        end
    end

    always @(negedge clk) begin
        if (crd) begin
            if (!bank_ok(csel)) begin
                cdata_rd = 20'hBAD00;
            end else if (mem.exists(mkey(csel, caddr_rd))) begin
                cdata_rd = mem[mkey(csel, caddr_rd)];
            end else begin
                cdata_rd = '0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_compared++;
        if (act_v !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL %s at t=%0t: got %0h, want %0h", name, $time, act_v, exp_v);
        end
    endtask

    // Reference model state: values the registered outputs must show this cycle.
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        bit            defined;
        int            due;
    } ret_t;

    ret_t            ret_q[$];
    logic [DW-1:0]   shadow [int];
    int              mptr = 0;
    int              cyc  = 0;
    logic [NREQ-1:0] model_gnt = '0;
    logic            exp_crd = 1'b0;
    logic            exp_cwr = 1'b0;
    logic [SW-1:0]   exp_csel = '0;
    logic [AW-1:0]   exp_caddr_rd = '0;
    logic [AW-1:0]   exp_caddr_wr = '0;
    logic [DW-1:0]   exp_cdata_wr = '0;

    // Compare every cycle, then advance the model by the transfer at the next edge.
    always @(negedge clk) begin : compare_proc
        logic [NREQ-1:0] act_n;
        logic [NREQ-1:0] egnt;
        logic [NREQ-1:0] ervalid;
        logic [SW-1:0]   s;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        bit              ebusy;
        int              g;
        ret_t            r;

        if (!reset) begin
            mptr = 0;
            ret_q.delete();
            exp_crd = 1'b0;
            exp_cwr = 1'b0;
            exp_csel = '0;
            exp_caddr_rd = '0;
            exp_caddr_wr = '0;
            exp_cdata_wr = '0;
        end

        act_n = req_rd | req_wr;
        g = -1;
        for (int i = NREQ - 1; i >= mptr; i--) begin
            if (act_n[i]) g = i;
        end
        if (g < 0) begin
            for (int i = mptr - 1; i >= 0; i--) begin
                if (act_n[i]) g = i;
            end
        end
        egnt = '0;
        if (g >= 0) egnt[g] = 1'b1;
        check_output("gnt", 32'(gnt), 32'(egnt));

        if (!reset) begin
            model_gnt = '0;
            check_output("rst_crd", 32'(crd), 32'd0);
            check_output("rst_cwr", 32'(cwr), 32'd0);
            check_output("rst_csel", 32'(csel), 32'd0);
            check_output("rst_caddr_rd", 32'(caddr_rd), 32'd0);
            check_output("rst_caddr_wr", 32'(caddr_wr), 32'd0);
            check_output("rst_cdata_wr", 32'(cdata_wr), 32'd0);
            check_output("rst_rvalid", 32'(rvalid), 32'd0);
            check_output("rst_rdata", 32'(rdata), 32'd0);
            check_output("rst_busy", 32'(arb_busy), 32'(|act_n));
        end else begin
            ebusy = (act_n != '0) || (ret_q.size() > 0);
            ervalid = '0;
            check_output("crd", 32'(crd), 32'(exp_crd));
            check_output("cwr", 32'(cwr), 32'(exp_cwr));
            check_output("csel", 32'(csel), 32'(exp_csel));
            check_output("caddr_rd", 32'(caddr_rd), 32'(exp_caddr_rd));
            check_output("caddr_wr", 32'(caddr_wr), 32'(exp_caddr_wr));
            check_output("cdata_wr", 32'(cdata_wr), 32'(exp_cdata_wr));
            check_output("arb_busy", 32'(arb_busy), 32'(ebusy));
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                r = ret_q.pop_front();
                ervalid[r.id] = 1'b1;
                if (r.defined) begin
                    check_output("rdata", 32'(rdata), 32'(r.data));
                end
            end
            check_output("rvalid", 32'(rvalid), 32'(ervalid));

            model_gnt = egnt;
            if (g >= 0) begin
                s = req_sel[g*SW +: SW];
                a = req_addr[g*AW +: AW];
                d = req_wdata[g*DW +: DW];
                mptr = (g + 1) % NREQ;
                exp_csel = s;
                if (req_wr[g]) begin
                    exp_cwr = 1'b1;
                    exp_crd = 1'b0;
                    exp_caddr_wr = a;
                    exp_cdata_wr = d;
                    if (bank_ok(s)) shadow[mkey(s, a)] = d;
                end else begin
                    exp_crd = 1'b1;
                    exp_cwr = 1'b0;
                    exp_caddr_rd = a;
                    r.id = g;
                    r.defined = bank_ok(s);
                    r.data = (bank_ok(s) && shadow.exists(mkey(s, a))) ? shadow[mkey(s, a)] : '0;
                    r.due = cyc + 2;
                    ret_q.push_back(r);
                end
            end else begin
                exp_crd = 1'b0;
                exp_cwr = 1'b0;
                exp_csel = '0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int i, input logic rd, input logic wr, input logic [SW-1:0] s,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_sel[i*SW +: SW] = s;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Random traffic: each engine holds its request until granted, then may issue another.
    task automatic apply_stimulus(input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (model_gnt[i]) begin
                    if (req_wr[i]) req_wr[i] = 1'b0;
                    else req_rd[i] = 1'b0;
                end
                if (!req_rd[i] && !req_wr[i] && $urandom_range(0, 99) < 45) begin
                    int kind;
                    logic [SW-1:0] s;
                    kind = $urandom_range(0, 9);
                    s = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(0, 7)) : SW'($urandom_range(1, 5));
                    set_eng(i, kind < 5 || kind == 9, kind >= 5, s,
                            AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
            tick();
        end
    endtask

    logic [NREQ-1:0] rr_seq [3] = '{3'b001, 3'b010, 3'b100};

    initial begin
        reset = 1'b0;
        req_rd = '0;
        req_wr = '0;
        req_sel = '0;
        req_addr = '0;
        req_wdata = '0;

        // Reset then idle.
        repeat (3) tick();
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_output("idle_gnt", 32'(gnt), 32'd0);
            check_output("idle_busy", 32'(arb_busy), 32'd0);
            check_output("idle_crd", 32'(crd | cwr), 32'd0);
            check_output("idle_rvalid", 32'(rvalid), 32'd0);
        end

        // Engine 0 writes then reads back the same location.
        tick();
        set_eng(0, 1'b0, 1'b1, 3'd1, 12'h005, 20'h0ABCD);
        tick();
        set_eng(0, 1'b1, 1'b0, 3'd1, 12'h005, 20'h0);
        @(negedge clk);
        check_output("wr0_cwr", 32'(cwr), 32'd1);
        check_output("wr0_csel", 32'(csel), 32'd1);
        check_output("wr0_caddr_wr", 32'(caddr_wr), 32'h005);
        tick();
        req_rd[0] = 1'b0;
        @(negedge clk);
        check_output("rd0_crd", 32'(crd), 32'd1);
        tick();
        @(negedge clk);
        check_output("rd0_rvalid", 32'(rvalid), 32'b001);
        check_output("rd0_rdata", 32'(rdata), 32'h0ABCD);

        // Engine 1 asks for write and read together: write first, read next turn.
        tick();
        set_eng(1, 1'b1, 1'b1, 3'd2, 12'h010, 20'h00011);
        tick();
        req_wr[1] = 1'b0;
        @(negedge clk);
        check_output("rw1_cwr", 32'(cwr), 32'd1);
        check_output("rw1_cdata_wr", 32'(cdata_wr), 32'h00011);
        check_output("rw1_gnt", 32'(gnt), 32'b010);
        tick();
        req_rd[1] = 1'b0;
        @(negedge clk);
        check_output("rw1_crd", 32'(crd), 32'd1);
        check_output("rw1_caddr_rd", 32'(caddr_rd), 32'h010);
        tick();
        @(negedge clk);
        check_output("rw1_rvalid", 32'(rvalid), 32'b010);
        check_output("rw1_rdata", 32'(rdata), 32'h00011);

        // Engine 2 writes, engine 0 reads the same bank-5 location on the next edge.
        tick();
        set_eng(2, 1'b0, 1'b1, 3'd5, 12'h3FF, 20'h5A5A5);
        tick();
        req_wr[2] = 1'b0;
        set_eng(0, 1'b1, 1'b0, 3'd5, 12'h3FF, 20'h0);
        tick();
        req_rd[0] = 1'b0;
        tick();
        @(negedge clk);
        check_output("raw_rvalid", 32'(rvalid), 32'b001);
        check_output("raw_rdata", 32'(rdata), 32'h5A5A5);

        // Only engine 2 reading, four back-to-back reads.
        tick();
        for (int j = 0; j < 4; j++) begin
            set_eng(2, 1'b1, 1'b0, 3'd3, AW'(12'h020 + j), 20'h0);
            @(negedge clk);
            check_output("solo2_gnt", 32'(gnt), 32'b100);
            tick();
        end
        req_rd[2] = 1'b0;
        @(negedge clk);
        check_output("solo2_busy_t0", 32'(arb_busy), 32'd1);
        tick();
        @(negedge clk);
        check_output("solo2_busy_t1", 32'(arb_busy), 32'd1);
        check_output("solo2_rvalid", 32'(rvalid), 32'b100);
        tick();
        @(negedge clk);
        check_output("solo2_busy_end", 32'(arb_busy), 32'd0);

        // Reset asserted while a read is in flight: that read never returns.
        tick();
        set_eng(0, 1'b1, 1'b0, 3'd1, 12'h005, 20'h0);
        tick();
        req_rd[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_output("rstmid_rvalid_a", 32'(rvalid), 32'd0);
        check_output("rstmid_crd", 32'(crd), 32'd0);
        tick();
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check_output("rstmid_rvalid_b", 32'(rvalid), 32'd0);
            tick();
        end

        // All three engines reading continuously from reset.
        reset = 1'b0;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            set_eng(i, 1'b1, 1'b0, SW'($urandom_range(1, 5)), AW'($urandom_range(0, 15)), 20'h0);
        end
        tick();
        reset = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            check_output("all3_gnt", 32'(gnt), 32'(rr_seq[j % 3]));
            if (j >= 2) check_output("all3_rvalid", 32'(rvalid), 32'(rr_seq[(j - 2) % 3]));
            if (j >= 1) check_output("all3_crd", 32'(crd), 32'd1);
            tick();
            req_addr[(j % 3)*AW +: AW] = AW'($urandom_range(0, 15));
        end
        req_rd = '0;
        repeat (3) tick();

        // Randomized traffic against the model.
        apply_stimulus(1500);
        req_rd = '0;
        req_wr = '0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
